gamma_key_sequencer: RTL
========================

Name: gamma_key_sequencer

Overview:
- Controller that sequences the gamma decoder datapath for one frame of FRAME_LEN words.
- Generates the per-word noise key from a seeded Galois LFSR.
- Accepts mixed words over a valid/ready handshake and presents each word with its aligned key to the registered subtractor datapath.
- Tracks datapath latency so that out_valid and done line up with decoded data leaving the pipeline.

Parameters:
SIZE, 8, data width of key; mixed word is SIZE+1 bits
FRAME_LEN, 16, words per frame (>=2)
LAT, 2, cycles from dp_valid to decoded word valid at datapath output (>=1)
POLY, 8'hB8, Galois LFSR feedback mask (SIZE bits)

Ports:
clk  in  1  clock, rising edge
res_n  in  1  asynchronous reset, active-high (asserted = 1)
start  in  1  one-cycle pulse, begin a frame (honoured only in IDLE)
abort  in  1  synchronous abort, any state -> IDLE
seed  in  SIZE  LFSR seed, sampled on accepted start
in_valid  in  1  mixed word valid
in_ready  out  1  sequencer can accept a word
mix_data  in  SIZE+1  mixed input word
dp_mix  out  SIZE+1  word presented to datapath
key_out  out  SIZE  noise key presented to datapath
dp_valid  out  1  dp_mix/key_out valid this cycle
out_valid  out  1  decoded word valid at datapath output
word_cnt  out  $clog2(FRAME_LEN+1)  words accepted this frame
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, frame fully drained

Behaviour:
- Reset (res_n=1, async):
  - state=IDLE; lfsr=all-ones; dp_mix=0, key_out=0, word_cnt=0.
  - dp_valid, out_valid, done, busy, in_ready and the latency shift register all clear to 0.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD; lfsr<=seed, or all-ones if seed==0 (all-zero lockup is forbidden); word_cnt<=0.
- LOAD: single cycle, in_ready=0 -> RUN. First in_ready=1 occurs 2 cycles after the start edge.
- RUN:
  - in_ready=1 combinationally from state; it does not depend on in_valid.
  - Accept when in_valid & in_ready. On accept, registered:
    - dp_mix<=mix_data; key_out<=lfsr; dp_valid<=1.
    - lfsr<=lfsr[0] ? (lfsr>>1)^POLY : lfsr>>1.
    - word_cnt<=word_cnt+1.
  - No accept -> dp_valid<=0; lfsr, dp_mix and key_out hold.
  - Accept with word_cnt==FRAME_LEN-1 -> DRAIN, so in_ready drops the next cycle. Exactly FRAME_LEN words are accepted per frame.
- Key order: word 0 uses the seed value, word i uses the LFSR state after i steps.
- DRAIN:
  - in_ready=0; dp_valid<=0.
  - Wait until the latency shift register is empty (no pending out_valid).
  - On the cycle the last out_valid is asserted, assert done=1 (registered, one cycle) and go to IDLE.
- out_valid: dp_valid delayed by exactly LAT cycles through a shift register. Unaffected by in_valid gaps.
- start while busy: ignored; seed is not resampled.
- abort=1:
  - Next state IDLE.
  - Clears dp_valid, the out_valid shift register and word_cnt; no done pulse.
  - abort has priority over start and over an accept in the same cycle; that word is dropped.
- Reset mid-frame: immediate return to reset values; no partial done.
- word_cnt holds its final value (FRAME_LEN) in IDLE until the next start or abort.
- Widths: no arithmetic overflow within the block. The subtraction itself belongs to the datapath.

Test Plan:
- Reset, then start with seed=8'h01 and 4 back-to-back words:
  - key_out sequence is 01, B8, 5C, 2E.
  - dp_valid follows each accept by 1 cycle; out_valid follows dp_valid by LAT=2 cycles.
- seed=8'h00 -> first key_out=FF, second key_out=FF^... per POLY, i.e. 8'hC7 (FF>>1=7F ^ B8).
- Full frame, FRAME_LEN=16, in_valid always high:
  - Exactly 16 accepts; in_ready low from the cycle after the 16th accept.
  - done pulses once, coincident with the 16th out_valid; word_cnt=16.
- in_valid gaps (valid on alternate cycles):
  - LFSR advances only on accepts; key sequence is identical to the no-gap case.
  - out_valid pattern mirrors the gaps shifted by LAT.
- start pulsed during RUN with a different seed -> no effect on the key sequence or word_cnt.
- abort asserted after word 5 together with in_valid:
  - That word is not accepted; no out_valid afterwards; no done; busy=0 next cycle.
  - A new start then restarts from the new seed.

Source files
------------

// File: rtl/gamma_key_sequencer.sv
// Sequencer for the gamma decoder datapath: pairs each accepted mixed word with its
// Galois-LFSR noise key and tracks datapath latency so out_valid/done match the decoded output.
module gamma_key_sequencer #(
    parameter int              SIZE      = 8,
    parameter int              FRAME_LEN = 16,
    parameter int              LAT       = 2,
    parameter logic [SIZE-1:0] POLY      = 8'hB8
) (
    input  logic                               clk,
    input  logic                               res_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [SIZE-1:0]                    seed,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [SIZE:0]                      mix_data,
    output logic [SIZE:0]                      dp_mix,
    output logic [SIZE-1:0]                    key_out,
    output logic                               dp_valid,
    output logic                               out_valid,
    output logic [$clog2(FRAME_LEN+1)-1:0]     word_cnt,
    output logic                               busy,
    output logic                               done
);

    localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    function automatic logic [SIZE-1:0] lfsr_step(input logic [SIZE-1:0] s);
        logic [SIZE-1:0] shifted;
        shifted = {1'b0, s[SIZE-1:1]};
        if (s[0]) begin
            return shifted ^ POLY;
        end else begin
            return shifted;
        end
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
    function automatic logic [SIZE-1:0] seed_fix(input logic [SIZE-1:0] s);
        if (s == {SIZE{1'b0}}) begin
            return {SIZE{1'b1}};
        end else begin
            return s;
        end
    endfunction

    state_t            state_q,    state_d;
    logic [SIZE-1:0]   lfsr_q,     lfsr_d;
    logic [SIZE:0]     dp_mix_q,   dp_mix_d;
    logic [SIZE-1:0]   key_q,      key_d;
    logic              dp_valid_q, dp_valid_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [LAT-1:0]    lat_q,      lat_d;
    logic              done_q,     done_d;

    logic              in_ready_s;
    logic              accept_s;
    logic [LAT:0]      pend_s;
    logic              lower_pend_s;

    assign in_ready_s = (state_q == S_RUN);
    assign accept_s   = in_valid & in_ready_s;

    // Pending-valid view of the pipe: index 0 is dp_valid, index LAT is out_valid.
    always_comb begin
        pend_s       = {lat_q, dp_valid_q};
        lower_pend_s = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            lower_pend_s = lower_pend_s | pend_s[k];
        end
    end

    // Next-state, key generation and latency tracking.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        dp_mix_d   = dp_mix_q;
        key_d      = key_q;
        dp_valid_d = 1'b0;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        lat_d[0]   = dp_valid_q;
        for (int k = 1; k < LAT; k++) begin
            lat_d[k] = lat_q[k-1];
        end

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            lat_d   = {LAT{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        lfsr_d  = seed_fix(seed);
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (accept_s) begin
                        dp_mix_d   = mix_data;
                        key_d      = lfsr_q;
                        dp_valid_d = 1'b1;
                        lfsr_d     = lfsr_step(lfsr_q);
                        cnt_d      = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DRAIN: begin
                    // done is registered alongside the final out_valid entering the output stage.
                    if (pend_s[LAT-1] && !lower_pend_s) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                    lat_d   = {LAT{1'b0}};
                end
            endcase
        end
    end

    // State and datapath-facing registers.
    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= {SIZE{1'b1}};
            dp_mix_q   <= {(SIZE+1){1'b0}};
            key_q      <= {SIZE{1'b0}};
            dp_valid_q <= 1'b0;
            cnt_q      <= CNT_ZERO;
            lat_q      <= {LAT{1'b0}};
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            dp_mix_q   <= dp_mix_d;
            key_q      <= key_d;
            dp_valid_q <= dp_valid_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            done_q     <= done_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = (state_q != S_IDLE);
    assign dp_mix    = dp_mix_q;
    assign key_out   = key_q;
    assign dp_valid  = dp_valid_q;
    assign out_valid = lat_q[LAT-1];
    assign word_cnt  = cnt_q;
    assign done      = done_q;

endmodule
